// File: rtl/cache_fsm.sv
// Cache-side miss handler: resolves core requests as hit or miss and
// sequences the dirty write-back and refill bursts toward memory.
module cache_fsm #(
    parameter int BLOCK_WORDS = 16,
    parameter int CNT_W       = $clog2(BLOCK_WORDS)
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             i_start,
    input  logic             i_write,
    input  logic             i_hit,
    input  logic             i_dirty,
    input  logic             i_mem_ready,
    output logic             o_stall,
    output logic             o_mem_req,
    output logic             o_mem_we,
    output logic             o_addr_sel,
    output logic [CNT_W-1:0] o_beat_cnt,
    output logic             o_data_we,
    output logic             o_line_fill,
    output logic             o_tag_we,
    output logic             o_dirty_set,
    output logic             o_dirty_clr
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE_BACK,
        S_ALLOCATE,
        S_REFILL_DONE
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_last;

    assign w_last     = (r_cnt == CNT_W'(BLOCK_WORDS - 1));
    assign o_beat_cnt = r_cnt;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_cnt_nxt   = r_cnt;
        o_stall     = 1'b0;
        o_mem_req   = 1'b0;
        o_mem_we    = 1'b0;
        o_addr_sel  = 1'b0;
        o_data_we   = 1'b0;
        o_line_fill = 1'b0;
        o_tag_we    = 1'b0;
        o_dirty_set = 1'b0;
        o_dirty_clr = 1'b0;
        // Strobes are forced quiet while reset is held so nothing lands in the arrays.
        if (!arst) begin
            unique case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        if (i_hit) begin
                            o_data_we   = i_write;
                            o_dirty_set = i_write;
                        end else begin
                            o_stall   = 1'b1;
                            w_cnt_nxt = '0;
                            w_next    = i_dirty ? S_WRITE_BACK : S_ALLOCATE;
                        end
                    end
                end
                S_WRITE_BACK: begin
                    o_stall    = 1'b1;
                    o_mem_req  = 1'b1;
                    o_mem_we   = 1'b1;
                    o_addr_sel = 1'b1;
                    if (i_mem_ready) begin
                        w_cnt_nxt = r_cnt + 1'b1;
                        if (w_last) begin
                            w_next = S_ALLOCATE;
                        end
                    end
                end
                S_ALLOCATE: begin
                    o_stall   = 1'b1;
                    o_mem_req = 1'b1;
                    if (i_mem_ready) begin
                        o_data_we   = 1'b1;
                        o_line_fill = 1'b1;
                        w_cnt_nxt   = r_cnt + 1'b1;
                        if (w_last) begin
                            o_tag_we    = 1'b1;
                            o_dirty_clr = 1'b1;
                            w_next      = S_REFILL_DONE;
                        end
                    end
                end
                S_REFILL_DONE: begin
                    o_stall = 1'b1;
                    w_next  = S_IDLE;
                end
                default: begin
                    w_next    = S_IDLE;
                    w_cnt_nxt = '0;
                end
            endcase
        end
    end

endmodule

// File: doc/cache_fsm.md
Name: cache_fsm

Overview:
- Cache-side responder to the core FSM's start/stall request protocol; one instance per I-cache and per D-cache.
- Resolves each request as a hit or a miss and holds the core in stall while it handles a miss.
- A miss runs a dirty-victim write-back burst, then a line-refill burst, to external memory.
- Produces write strobes for the data, tag, valid and dirty arrays; the arrays themselves live outside this block.

Parameters:
- BLOCK_WORDS, 16, words per cache line = beats per memory burst; power of two, >= 2.
- CNT_W, $clog2(BLOCK_WORDS), beat counter width (derived).

Ports:
- clk  input  1  clock.
- arst  input  1  asynchronous active-high reset.
- i_start  input  1  request from core; held high by core until o_stall is low.
- i_write  input  1  request is a store; valid with i_start.
- i_hit  input  1  combinational tag compare for the requested address; valid whenever i_start is high.
- i_dirty  input  1  dirty bit of the indexed (victim) line.
- i_mem_ready  input  1  memory accepted (write) or delivered (read) one beat this cycle.
- o_stall  output  1  core must hold its current state.
- o_mem_req  output  1  burst active toward memory.
- o_mem_we  output  1  1 = write-back beat, 0 = refill beat.
- o_addr_sel  output  1  1 = memory address uses victim tag, 0 = requested tag.
- o_beat_cnt  output  CNT_W  current beat index within the line.
- o_data_we  output  1  write one word into the data array.
- o_line_fill  output  1  data array write source: 1 = memory, 0 = core store data.
- o_tag_we  output  1  write requested tag, set valid.
- o_dirty_set  output  1  set dirty bit of the indexed line.
- o_dirty_clr  output  1  clear dirty bit of the indexed line.

Behaviour:
- States: IDLE, WRITE_BACK, ALLOCATE, REFILL_DONE. Registered state and beat counter; all outputs are combinational from state and inputs.
- Reset: state = IDLE, counter = 0. With i_start = 0 in IDLE, every output is 0.
- Reset mid-burst: immediate return to IDLE and counter 0. A partial line is left invalid because o_tag_we never fired. Memory tolerates a dropped o_mem_req.
- IDLE, i_start & i_hit:
  - o_stall = 0, stay in IDLE, zero added latency.
  - If i_write: o_data_we = 1, o_line_fill = 0, o_dirty_set = 1 in the same cycle.
- IDLE, i_start & !i_hit:
  - o_stall = 1.
  - Next state is WRITE_BACK if i_dirty, else ALLOCATE. Counter = 0.
- IDLE, !i_start: nothing happens; i_hit and i_dirty are ignored.
- WRITE_BACK:
  - o_stall = 1, o_mem_req = 1, o_mem_we = 1, o_addr_sel = 1.
  - Counter increments only on i_mem_ready.
  - On i_mem_ready with counter = BLOCK_WORDS-1: counter wraps to 0, go to ALLOCATE.
- ALLOCATE:
  - o_stall = 1, o_mem_req = 1, o_mem_we = 0, o_addr_sel = 0.
  - On each i_mem_ready: o_data_we = 1, o_line_fill = 1, counter increments.
  - On i_mem_ready with counter = BLOCK_WORDS-1, additionally: o_tag_we = 1, o_dirty_clr = 1, counter wraps to 0, go to REFILL_DONE.
- REFILL_DONE:
  - o_stall = 1, no memory or array strobes.
  - Gives the tag array one cycle to re-read; always goes to IDLE.
  - The core's still-held i_start then resolves as a hit. A store hit therefore writes its word after the refill, with no merge logic needed.
- i_mem_ready low: state and counter hold; o_mem_req stays high.
- i_start dropping mid-miss: the burst still completes and the line is filled. No abort.
- o_dirty_set and o_dirty_clr are never both high in the same cycle.
- Latency with i_mem_ready tied high:
  - hit: 0 stall cycles;
  - clean miss: BLOCK_WORDS+2 stall cycles;
  - dirty miss: 2*BLOCK_WORDS+2 stall cycles.

Test Plan:
- Read hit (default params): i_start=1, i_write=0, i_hit=1 → o_stall=0 and all strobes 0 in that cycle; state stays IDLE.
- Store hit: i_start=1, i_write=1, i_hit=1 → same cycle o_stall=0, o_data_we=1, o_line_fill=0, o_dirty_set=1.
- Clean read miss, i_mem_ready=1, i_dirty=0:
  - o_stall high for 18 cycles;
  - 16 o_data_we pulses with o_beat_cnt 0..15;
  - o_tag_we and o_dirty_clr pulse on beat 15;
  - i_hit driven high from cycle 18 → o_stall=0.
- Dirty store miss, i_mem_ready=1, i_dirty=1:
  - 16 beats with o_mem_we=1 and o_addr_sel=1, then 16 refill beats;
  - o_stall high for 34 cycles;
  - then o_data_we with o_line_fill=0 and o_dirty_set=1 on the hit cycle.
- Backpressure on a clean miss, i_mem_ready alternating 1/0:
  - counter advances only on ready cycles;
  - ALLOCATE lasts 32 cycles;
  - exactly 16 o_data_we pulses.
- Reset during ALLOCATE at o_beat_cnt=7: arst=1 → all outputs 0 immediately; after release, state is IDLE with o_beat_cnt=0 and no o_tag_we was ever issued.
